// File: rtl/neo_irq_pkg.sv
// neo_irq_pkg: shared constants for the NeoGeo 68000 interrupt controller.
package neo_irq_pkg;

  localparam logic [1:0] LVL_NONE  = 2'd0;
  localparam logic [1:0] LVL_VBL   = 2'd1;
  localparam logic [1:0] LVL_TIMER = 2'd2;
  localparam logic [1:0] LVL_COLD  = 2'd3;

  localparam int PEND_VBL   = 0;
  localparam int PEND_TIMER = 1;
  localparam int PEND_COLD  = 2;

  // Word address (A23..A1) of the ack register at byte 0x3C000C, mirrored every 16 bytes
  localparam logic [22:0] ACK_ADDR_DEF = 23'h1E0006;
  localparam logic [22:0] ACK_MASK_DEF = 23'h7E0007;

  localparam logic [2:0] FC_IACK = 3'b111;

  // Highest pending flag wins
  function automatic logic [1:0] prio_level(input logic [2:0] pend);
    if (pend[PEND_COLD])       return LVL_COLD;
    else if (pend[PEND_TIMER]) return LVL_TIMER;
    else if (pend[PEND_VBL])   return LVL_VBL;
    else                       return LVL_NONE;
  endfunction

endpackage

// File: rtl/neo_irq_edge.sv
// neo_irq_edge: registered rising-edge detector. The first sample after reset
// only seeds the history, so a level held high through reset release is not an edge.
module neo_irq_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic       cur_q, cur_d;
  logic       prev_q, prev_d;
  logic [1:0] vld_pipe_q, vld_pipe_d;

  // Next history: sample input, shift previous, mark history as valid
  always_comb begin
    cur_d      = d;
    prev_d     = cur_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b1};
  end

  // History registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q      <= 1'b0;
      prev_q     <= 1'b0;
      vld_pipe_q <= 2'b00;
    end else begin
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign rise = cur_q & ~prev_q & vld_pipe_q[1];

endmodule

// File: rtl/neo_irq_ctrl.sv
// neo_irq_ctrl: latches VBL/timer/cold-boot interrupts, priority-encodes them
// onto active-low IPL, clears flags on writes to the ack register.
// Optional macro NEO_IRQ_IACK_AUTOCLR_EN: IACK cycles auto-clear the acked flag.
module neo_irq_ctrl
  import neo_irq_pkg::*;
#(
  parameter logic [22:0] ACK_ADDR = ACK_ADDR_DEF,
  parameter logic [22:0] ACK_MASK = ACK_MASK_DEF
) (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic        VBL_IRQ,
  input  logic        TIMER_IRQ,
  input  logic        COLD_IRQ,
  input  logic [22:0] M68K_ADDR,
  input  logic [15:0] M68K_DATA,
  input  logic        nAS,
  input  logic        M68K_RW,
  input  logic        nLDS,
  input  logic        FC2,
  input  logic        FC1,
  input  logic        FC0,
  output logic        IPL2,
  output logic        IPL1,
  output logic        IPL0,
  output logic [2:0]  IRQ_PENDING
);

  logic [2:0] src, rise;
  logic       nas_fall;

  assign src[PEND_VBL]   = VBL_IRQ;
  assign src[PEND_TIMER] = TIMER_IRQ;
  assign src[PEND_COLD]  = COLD_IRQ;

  for (genvar i = 0; i < 3; i++) begin : g_src
    neo_irq_edge u_edge (.clk(CLK_24M), .rst(RESET), .d(src[i]), .rise(rise[i]));
  end

  // Inverted input: registered nAS resets to 1, fall of nAS is a rise here
  neo_irq_edge u_nas (.clk(CLK_24M), .rst(RESET), .d(~nAS), .rise(nas_fall));

  // Bus qualifiers are captured on the same edge as nAS so they line up with nas_fall
  logic       wr_q, wr_d;
  logic       match_q, match_d;
  logic [2:0] dat_q, dat_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] ipl_q, ipl_d;
  logic [2:0] clr;

`ifdef NEO_IRQ_IACK_AUTOCLR_EN
  logic       iack_q, iack_d;
  logic [2:0] lvl_q, lvl_d;
  logic       unused_ok;
  assign unused_ok = ^M68K_DATA[15:3];
`else
  logic       unused_ok;
  assign unused_ok = ^{M68K_DATA[15:3], FC2, FC1, FC0};
`endif

  // Next-state: qualifier capture, flag clear/set (set wins), priority encode
  always_comb begin
    wr_d    = ~M68K_RW & ~nLDS;
    match_d = (M68K_ADDR & ACK_MASK) == (ACK_ADDR & ACK_MASK);
    dat_d   = M68K_DATA[2:0];
    clr     = 3'b000;
    if (nas_fall && wr_q && match_q) begin
      clr[PEND_COLD]  = dat_q[0];
      clr[PEND_TIMER] = dat_q[1];
      clr[PEND_VBL]   = dat_q[2];
    end
`ifdef NEO_IRQ_IACK_AUTOCLR_EN
    iack_d = ({FC2, FC1, FC0} == FC_IACK) && M68K_RW;
    lvl_d  = M68K_ADDR[2:0];
    if (nas_fall && iack_q) begin
      case (lvl_q)
        3'd1:    clr[PEND_VBL]   = 1'b1;
        3'd2:    clr[PEND_TIMER] = 1'b1;
        3'd3:    clr[PEND_COLD]  = 1'b1;
        default: ;
      endcase
    end
`endif
    pend_d = (pend_q & ~clr) | rise;
    ipl_d  = ~{1'b0, prio_level(pend_q)};
  end

  // State registers, cleared asynchronously
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      wr_q    <= 1'b0;
      match_q <= 1'b0;
      dat_q   <= 3'b000;
      pend_q  <= 3'b000;
      ipl_q   <= 3'b111;
`ifdef NEO_IRQ_IACK_AUTOCLR_EN
      iack_q  <= 1'b0;
      lvl_q   <= 3'b000;
`endif
    end else begin
      wr_q    <= wr_d;
      match_q <= match_d;
      dat_q   <= dat_d;
      pend_q  <= pend_d;
      ipl_q   <= ipl_d;
`ifdef NEO_IRQ_IACK_AUTOCLR_EN
      iack_q  <= iack_d;
      lvl_q   <= lvl_d;
`endif
    end
  end

  assign {IPL2, IPL1, IPL0} = ipl_q;
  assign IRQ_PENDING        = pend_q;

endmodule

// File: tb/tb_neo_irq_ctrl.sv
// tb_neo_irq_ctrl: scenario tasks push expected {pending, ipl} to a scoreboard
// when stimulus is driven and pop/compare once the DUT latency has elapsed.
module tb_neo_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vbl = 1'b0, tmr = 1'b0, cold = 1'b0;
  logic [22:0] addr = '0;
  logic [15:0] data = '0;
  logic        nas = 1'b1, rw = 1'b1, nlds = 1'b1;
  logic [2:0]  fc = 3'b000;
  logic        ipl2, ipl1, ipl0;
  logic [2:0]  pend;

  typedef struct {
    string      name;
    logic [2:0] pend;
    logic [2:0] ipl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_mis = 0;

  neo_irq_ctrl dut (
    .CLK_24M(clk), .RESET(rst), .VBL_IRQ(vbl), .TIMER_IRQ(tmr), .COLD_IRQ(cold),
    .M68K_ADDR(addr), .M68K_DATA(data), .nAS(nas), .M68K_RW(rw), .nLDS(nlds),
    .FC2(fc[2]), .FC1(fc[1]), .FC0(fc[0]),
    .IPL2(ipl2), .IPL1(ipl1), .IPL0(ipl0), .IRQ_PENDING(pend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input string name, input logic [2:0] p, input logic [2:0] i);
    exp_t x;
    x.name = name; x.pend = p; x.ipl = i;
    q.push_back(x);
  endtask

  // Drive a bus cycle at the falling clock edge; nAS falls with everything else
  task automatic bus_start(input logic [22:0] a, input logic [15:0] d,
                           input logic r, input logic l, input logic [2:0] f);
    @(negedge clk);
    addr = a; data = d; rw = r; nlds = l; fc = f; nas = 1'b0;
  endtask

  task automatic bus_end;
    @(negedge clk);
    nas = 1'b1; rw = 1'b1; nlds = 1'b1; fc = 3'b000;
  endtask

  task automatic test_reset_state;
    push("reset_state", 3'b000, 3'b111);
    tick(2);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
  endtask

  task automatic test_single;
    @(negedge clk); vbl = 1'b1;
    push("single_pend", 3'b001, 3'b111);
    push("single_ipl", 3'b001, 3'b110);
    tick(1);
    @(negedge clk); vbl = 1'b0;
    tick(1);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    tick(1);
    e = q.pop_front();
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    // ack vblank via byte 0x3C000C
    bus_start(23'h1E0006, 16'h0004, 1'b0, 1'b0, 3'b000);
    push("single_ack_flag", 3'b000, 3'b110);
    push("single_ack_ipl", 3'b000, 3'b111);
    tick(2);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    tick(1);
    e = q.pop_front();
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_end();
  endtask

  task automatic test_priority;
    @(negedge clk); vbl = 1'b1; tmr = 1'b1;
    push("prio_vbl_tmr", 3'b011, 3'b101);
    tick(1);
    @(negedge clk); vbl = 1'b0; tmr = 1'b0;
    tick(2);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_start(23'h1E0006, 16'h0002, 1'b0, 1'b0, 3'b000);
    push("prio_ack_tmr", 3'b001, 3'b110);
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_end();
    @(negedge clk); cold = 1'b1;
    push("prio_cold", 3'b101, 3'b100);
    tick(1);
    @(negedge clk); cold = 1'b0;
    tick(2);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
  endtask

  task automatic test_mirror;
    // byte 0x3DFFFC is a mirror of the ack register
    bus_start(23'h1EFFFE, 16'h0007, 1'b0, 1'b0, 3'b000);
    push("mirror_clear", 3'b000, 3'b111);
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_end();
    @(negedge clk); vbl = 1'b1; tmr = 1'b1;
    tick(1);
    @(negedge clk); vbl = 1'b0; tmr = 1'b0;
    tick(2);
    // 0x3C000E with nLDS high, then a read of 0x3C000C: neither acks
    bus_start(23'h1E0007, 16'h0007, 1'b0, 1'b1, 3'b000);
    push("nomatch_lds", 3'b011, 3'b101);
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    bus_end();
    bus_start(23'h1E0006, 16'h0007, 1'b1, 1'b0, 3'b000);
    push("nomatch_read", 3'b011, 3'b101);
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_end();
    // upper data bits ignored; bit 1 clears timer only
    bus_start(23'h1E0006, 16'hFFF2, 1'b0, 1'b0, 3'b000);
    push("upper_bits", 3'b001, 3'b110);
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_end();
    bus_start(23'h1E0006, 16'h0007, 1'b0, 1'b0, 3'b000);
    tick(3);
    bus_end();
  endtask

  task automatic test_collision;
    @(negedge clk); tmr = 1'b1;
    tick(1);
    @(negedge clk); tmr = 1'b0;
    tick(2);
    // new timer rise arrives in the same cycle as the timer ack
    bus_start(23'h1E0006, 16'h0002, 1'b0, 1'b0, 3'b000);
    tmr = 1'b1;
    push("collision", 3'b010, 3'b101);
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_end();
    tmr = 1'b0;
    // repeated rise on an already pending flag changes nothing
    @(negedge clk); tmr = 1'b1;
    push("repeat_rise", 3'b010, 3'b101);
    tick(1);
    @(negedge clk); tmr = 1'b0;
    tick(2);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
  endtask

  task automatic test_iack;
    // timer still pending from previous scenario
    bus_start(23'h000002, 16'h0000, 1'b1, 1'b0, 3'b111);
`ifdef NEO_IRQ_IACK_AUTOCLR_EN
    push("iack", 3'b000, 3'b111);
`else
    push("iack", 3'b010, 3'b101);
`endif
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    bus_end();
    bus_start(23'h1E0006, 16'h0007, 1'b0, 1'b0, 3'b000);
    tick(3);
    bus_end();
  endtask

  task automatic test_reset_mid;
    @(negedge clk); vbl = 1'b1; tmr = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    push("reset_async", 3'b000, 3'b111);
    #1;
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    @(negedge clk); rst = 1'b0;
    push("reset_held_src", 3'b000, 3'b111);
    tick(6);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
    @(negedge clk); vbl = 1'b0;
    tick(1);
    @(negedge clk); vbl = 1'b1;
    push("reset_retoggle", 3'b001, 3'b110);
    tick(3);
    e = q.pop_front();
    n_cmp++;
    if (pend !== e.pend) begin n_mis++; $display("FAIL %s pend: got %b want %b", e.name, pend, e.pend); end
    n_cmp++;
    if ({ipl2, ipl1, ipl0} !== e.ipl) begin n_mis++; $display("FAIL %s ipl: got %b want %b", e.name, {ipl2, ipl1, ipl0}, e.ipl); end
  endtask

  initial begin
    rst = 1'b1;
    #23 rst = 1'b0;
    test_reset_state();
    test_single();
    test_priority();
    test_mirror();
    test_collision();
    test_iack();
    test_reset_mid();
    if (q.size() != 0) begin
      n_cmp++; n_mis++;
      $display("FAIL scoreboard_drain: %0d left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
